// File: rtl/lcd_display_sysid_pkg.sv
// rtl/lcd_display_sysid_pkg.sv - word map and control/status bit positions for the sysid peripheral
package lcd_display_sysid_pkg;

    // Word addresses on the 3-bit control-bus address
    localparam logic [2:0] ADDR_ID        = 3'd0;
    localparam logic [2:0] ADDR_TIMESTAMP = 3'd1;
    localparam logic [2:0] ADDR_UPTIME_LO = 3'd2;
    localparam logic [2:0] ADDR_UPTIME_HI = 3'd3;
    localparam logic [2:0] ADDR_SCRATCH   = 3'd4;
    localparam logic [2:0] ADDR_CTRL      = 3'd5;

    // CTRL_STAT bit indices
    localparam int CTRL_EN   = 0;
    localparam int CTRL_CLR  = 1;
    localparam int CTRL_WRAP = 8;

endpackage

// File: rtl/lcd_display_sysid_uptime.sv
// rtl/lcd_display_sysid_uptime.sv - free-running uptime counter with enable, clear and wrap pulse
//
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   en             : count enable
//   clr            : zero the counter at this edge; overrides counting and suppresses wrap
//   count          : current counter value
//   wrap           : combinational pulse, high in the cycle whose edge rolls the counter to 0
module lcd_display_sysid_uptime #(
    parameter int UPTIME_WIDTH = 64
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    en,
    input  logic                    clr,
    output logic [UPTIME_WIDTH-1:0] count,
    output logic                    wrap
);

    // A clear in the same cycle as the roll-over wins, so no wrap is reported.
    assign wrap = en && !clr && (&count);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + UPTIME_WIDTH'(1);
        end
    end

endmodule

// File: rtl/lcd_display_sysid_ext.sv
// rtl/lcd_display_sysid_ext.sv - registered system-ID, uptime, scratch and control/status slave
//
// Ports:
//   clock, reset_n  : clock and asynchronous active-low reset
//   address         : word address (0 ID, 1 timestamp, 2 uptime lo, 3 uptime hi snapshot,
//                     4 scratch, 5 control/status, 6-7 reserved)
//   read, write     : single-cycle strobes; a write wins when both are high
//   writedata       : write data
//   readdata        : registered read data, held between responses
//   readdatavalid   : one-cycle pulse one clock after an accepted read
module lcd_display_sysid_ext
    import lcd_display_sysid_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID     = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP     = 32'd1429741001,
    parameter int          UPTIME_WIDTH  = 64,
    parameter logic [31:0] SCRATCH_RESET = 32'hDEAD_BEEF
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    logic [UPTIME_WIDTH-1:0] count;
    logic                    wrap_pulse;
    logic [31:0]             count_hi;
    logic [31:0]             hi_snap;
    logic [31:0]             scratch;
    logic                    en;
    logic                    wrap_flag;
    logic                    rd_accept;
    logic                    wr_ctrl;
    logic                    clr;
    logic                    wrap_w1c;
    logic [31:0]             ctrl_word;
    logic [31:0]             rd_mux;

    // A simultaneous write drops the read entirely.
    assign rd_accept = read && !write;
    assign wr_ctrl   = write && (address == ADDR_CTRL);
    assign clr       = wr_ctrl && writedata[CTRL_CLR];
    assign wrap_w1c  = wr_ctrl && writedata[CTRL_WRAP];

    // Upper counter bits, zero-extended to a full word.
    assign count_hi = 32'(count[UPTIME_WIDTH-1:32]);

    lcd_display_sysid_uptime #(
        .UPTIME_WIDTH(UPTIME_WIDTH)
    ) u_uptime (
        .clock  (clock),
        .reset_n(reset_n),
        .en     (en),
        .clr    (clr),
        .count  (count),
        .wrap   (wrap_pulse)
    );

    always_comb begin
        ctrl_word            = '0;
        ctrl_word[CTRL_EN]   = en;
        ctrl_word[CTRL_WRAP] = wrap_flag;
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_ID:        rd_mux = SYSTEM_ID;
            ADDR_TIMESTAMP: rd_mux = TIMESTAMP;
            ADDR_UPTIME_LO: rd_mux = count[31:0];
            ADDR_UPTIME_HI: rd_mux = hi_snap;
            ADDR_SCRATCH:   rd_mux = scratch;
            ADDR_CTRL:      rd_mux = ctrl_word;
            default:        rd_mux = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
            hi_snap       <= '0;
            scratch       <= SCRATCH_RESET;
            en            <= 1'b1;
            wrap_flag     <= 1'b0;
        end else begin
            readdatavalid <= rd_accept;
            if (rd_accept) begin
                readdata <= rd_mux;
            end
            // Reading the low half freezes the matching high half for a later word-3 read.
            if (rd_accept && (address == ADDR_UPTIME_LO)) begin
                hi_snap <= count_hi;
            end
            if (write && (address == ADDR_SCRATCH)) begin
                scratch <= writedata;
            end
            if (wr_ctrl) begin
                en <= writedata[CTRL_EN];
            end
            // Hardware set beats a same-cycle software clear.
            wrap_flag <= wrap_pulse || (wrap_flag && !wrap_w1c);
        end
    end

endmodule

// File: tb/tb_lcd_display_sysid_ext.sv
// tb/tb_lcd_display_sysid_ext.sv - randomized self-checking bench with a behavioural model of the sysid slave
module tb_lcd_display_sysid_ext;

    localparam int          UW      = 40;
    localparam logic [31:0] SYS_ID  = 32'h0000_0000;
    localparam logic [31:0] TSTAMP  = 32'd1429741001;
    localparam logic [31:0] SC_RST  = 32'hDEAD_BEEF;

    logic        clock;
    logic        reset_n;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        readdatavalid;

    int checks;
    int errors;

    // Behavioural model of the software-visible state
    logic [UW-1:0] m_count;
    logic [31:0]   m_hi;
    logic [31:0]   m_scratch;
    logic          m_en;
    logic          m_wrap;
    logic [31:0]   m_rdata;

    lcd_display_sysid_ext #(
        .SYSTEM_ID    (SYS_ID),
        .TIMESTAMP    (TSTAMP),
        .UPTIME_WIDTH (UW),
        .SCRATCH_RESET(SC_RST)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .address      (address),
        .read         (read),
        .write        (write),
        .writedata    (writedata),
        .readdata     (readdata),
        .readdatavalid(readdatavalid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_count   = '0;
        m_hi      = '0;
        m_scratch = SC_RST;
        m_en      = 1'b1;
        m_wrap    = 1'b0;
        m_rdata   = '0;
    endtask

    // Word the model returns for a read at the current (pre-edge) state
    function automatic logic [31:0] model_word(input logic [2:0] a);
        case (a)
            3'd0:    return SYS_ID;
            3'd1:    return TSTAMP;
            3'd2:    return m_count[31:0];
            3'd3:    return m_hi;
            3'd4:    return m_scratch;
            3'd5:    return {23'd0, m_wrap, 7'd0, m_en};
            default: return 32'd0;
        endcase
    endfunction

    // One bus cycle: drive after a falling edge, update the model at the rising edge,
    // check the response at the next falling edge.
    task automatic cycle(input logic rd, input logic wr, input logic [2:0] a,
                         input logic [31:0] d, output logic [31:0] obs);
        logic exp_v;
        logic hw_wrap;
        read = rd; write = wr; address = a; writedata = d;
        @(posedge clock);
        exp_v = rd && !wr;
        if (exp_v) begin
            m_rdata = model_word(a);
            if (a == 3'd2) m_hi = 32'(m_count >> 32);
        end
        hw_wrap = 1'b0;
        if (wr && a == 3'd5 && d[1]) begin
            m_count = '0;
        end else if (m_en) begin
            if (m_count == {UW{1'b1}}) hw_wrap = 1'b1;
            m_count = m_count + 1'b1;
        end
        m_wrap = hw_wrap || (m_wrap && !(wr && a == 3'd5 && d[8]));
        if (wr && a == 3'd5) m_en = d[0];
        if (wr && a == 3'd4) m_scratch = d;
        @(negedge clock);
        check("readdatavalid", {63'd0, readdatavalid}, {63'd0, exp_v});
        check("readdata", {32'd0, readdata}, {32'd0, m_rdata});
        obs = readdata;
        read = 1'b0; write = 1'b0;
    endtask

    task automatic rd_word(input logic [2:0] a, output logic [31:0] obs);
        cycle(1'b1, 1'b0, a, 32'd0, obs);
    endtask

    task automatic wr_word(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        cycle(1'b0, 1'b1, a, d, dummy);
    endtask

    task automatic idle(input int n);
        logic [31:0] dummy;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 3'd0, 32'd0, dummy);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] r2;
        logic        rd_r, wr_r;
        checks = 0; errors = 0;
        read = 0; write = 0; address = '0; writedata = '0;
        reset_n = 1'b0;
        model_reset();
        @(negedge clock);
        check("reset_rdv", {63'd0, readdatavalid}, 64'd0);
        check("reset_rdata", {32'd0, readdata}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // First read after release sees counter still at 0
        rd_word(3'd2, r);
        check("uptime_first", {32'd0, r}, 64'd0);
        rd_word(3'd0, r); check("sysid", {32'd0, r}, {32'd0, SYS_ID});
        rd_word(3'd1, r); check("timestamp", {32'd0, r}, 64'd1429741001);
        rd_word(3'd4, r); check("scratch_rst", {32'd0, r}, 64'hDEADBEEF);
        rd_word(3'd5, r); check("ctrl_rst", {32'd0, r}, 64'h1);

        wr_word(3'd4, 32'h1234_5678);
        rd_word(3'd4, r); check("scratch_wr", {32'd0, r}, 64'h12345678);
        wr_word(3'd1, 32'hFFFF_0000);
        rd_word(3'd1, r); check("ts_ro", {32'd0, r}, 64'd1429741001);
        wr_word(3'd6, 32'h5555_5555);
        rd_word(3'd6, r); check("reserved", {32'd0, r}, 64'd0);

        // Coherent split read across a 32-bit carry
        force dut.u_uptime.count = 40'h01_FFFF_FFFF;
        #1 release dut.u_uptime.count;
        m_count = 40'h01_FFFF_FFFF;
        rd_word(3'd2, r); check("lo_snap", {32'd0, r}, 64'hFFFFFFFF);
        idle(5);
        rd_word(3'd3, r); check("hi_snap", {32'd0, r}, 64'h1);

        // Wrap of the 40-bit counter
        wr_word(3'd5, 32'h101);
        force dut.u_uptime.count = {UW{1'b1}};
        #1 release dut.u_uptime.count;
        m_count = {UW{1'b1}};
        idle(1);
        rd_word(3'd5, r); check("wrap_set", {32'd0, r}, 64'h101);
        wr_word(3'd5, 32'h101);
        rd_word(3'd5, r); check("wrap_clr", {32'd0, r}, 64'h1);

        // Disabled counter holds; clear restarts from 0
        wr_word(3'd5, 32'h0);
        idle(10);
        rd_word(3'd2, r);
        rd_word(3'd2, r2);
        check("en_hold", {32'd0, r2}, {32'd0, r});
        wr_word(3'd5, 32'h3);
        rd_word(3'd2, r); check("clr_zero", {32'd0, r}, 64'd0);
        rd_word(3'd2, r); check("clr_count", {32'd0, r}, 64'd1);
        rd_word(3'd5, r); check("clr_ctrl", {32'd0, r}, 64'h1);

        // Read and write together: write only
        cycle(1'b1, 1'b1, 3'd4, 32'hA5A5_A5A5, r);
        rd_word(3'd4, r); check("rw_both", {32'd0, r}, 64'hA5A5A5A5);

        // Reset asserted while a response is pending
        read = 1'b1; address = 3'd4;
        @(posedge clock);
        #1 reset_n = 1'b0;
        read = 1'b0;
        model_reset();
        @(negedge clock);
        check("rst_mid_rdv", {63'd0, readdatavalid}, 64'd0);
        check("rst_mid_rdata", {32'd0, readdata}, 64'd0);
        @(negedge clock);
        check("rst_mid_rdv2", {63'd0, readdatavalid}, 64'd0);
        reset_n = 1'b1;
        rd_word(3'd4, r); check("rst_scratch", {32'd0, r}, 64'hDEADBEEF);
        rd_word(3'd5, r); check("rst_ctrl", {32'd0, r}, 64'h1);
        rd_word(3'd3, r); check("rst_hi", {32'd0, r}, 64'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            rd_r = 1'($urandom_range(0, 1));
            wr_r = ($urandom_range(0, 3) == 0);
            if (i % 97 == 50) begin
                force dut.u_uptime.count = {UW{1'b1}} - 40'($urandom_range(0, 2));
                #1 release dut.u_uptime.count;
                m_count = dut.u_uptime.count;
                m_count = {UW{1'b1}} - 40'(({UW{1'b1}} - m_count));
            end
            cycle(rd_r, wr_r, 3'($urandom_range(0, 7)), $urandom, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
